// File: rtl/ex_mem_latch.sv
// ex_mem_latch
// Pipeline register between the EX and MEM stages.
// Captures the ALU result, store data, destination register and the
// memory/writeback controls. Honours flush, stall and halt. Blocks misaligned
// accesses before they reach data memory. Provides a forwarding tap and a
// saturating retired-instruction counter for the debug unit.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_stall, i_flush    hold contents / load a bubble (flush wins)
//   i_valid, i_halt     EX slot holds a real instruction / it is HALT
//   i_alu_result        effective address or ALU result
//   i_store_data        store data (rt)
//   i_rd_addr           destination register
//   i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write, i_BHW  controls
//   o_valid .. o_mem_to_reg  registered copies for the MEM stage
//   o_fwd_en            forwarding tap for the EX-stage bypass mux
//   o_misalign          one-cycle pulse: slot holds a blocked access
//   o_misalign_addr     address of the first blocked access since reset
//   o_halted            sticky: HALT reached MEM
//   o_instr_count       saturating retired-instruction count
module ex_mem_latch #(
  parameter int NB_WIDTH = 32,
  parameter int NB_REG   = 5,
  parameter int NB_CNT   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [NB_WIDTH-1:0] i_alu_result,
  input  logic [NB_WIDTH-1:0] i_store_data,
  input  logic [NB_REG-1:0]   i_rd_addr,
  input  logic                i_reg_write,
  input  logic                i_mem_to_reg,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [2:0]          i_BHW,
  input  logic                i_halt,
  output logic                o_valid,
  output logic [NB_WIDTH-1:0] o_mem_addr,
  output logic [NB_WIDTH-1:0] o_mem_data,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [2:0]          o_BHW,
  output logic [NB_REG-1:0]   o_rd_addr,
  output logic                o_reg_write,
  output logic                o_mem_to_reg,
  output logic                o_fwd_en,
  output logic                o_misalign,
  output logic [NB_WIDTH-1:0] o_misalign_addr,
  output logic                o_halted,
  output logic [NB_CNT-1:0]   o_instr_count
);

  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  // Byte codes never fault; halfword needs addr[0]=0; word and any
  // undefined code need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] bhw,
                                         input logic [1:0] addr_lo);
    logic fault;
    case (bhw)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = addr_lo[0];
      default:        fault = |addr_lo;
    endcase
    return fault;
  endfunction

  logic                valid_r,         valid_nxt_s;
  logic [NB_WIDTH-1:0] addr_r,          addr_nxt_s;
  logic [NB_WIDTH-1:0] data_r,          data_nxt_s;
  logic                mem_read_r,      mem_read_nxt_s;
  logic                mem_write_r,     mem_write_nxt_s;
  logic [2:0]          bhw_r,           bhw_nxt_s;
  logic [NB_REG-1:0]   rd_r,            rd_nxt_s;
  logic                reg_write_r,     reg_write_nxt_s;
  logic                mem_to_reg_r,    mem_to_reg_nxt_s;
  logic                fwd_en_r,        fwd_en_nxt_s;
  logic                misalign_r,      misalign_nxt_s;
  logic [NB_WIDTH-1:0] misalign_addr_r, misalign_addr_nxt_s;
  logic                misalign_seen_r, misalign_seen_nxt_s;
  logic                halted_r,        halted_nxt_s;
  logic [NB_CNT-1:0]   count_r,         count_nxt_s;

  logic                bubble_s;
  logic                fault_s;

  // Next-state selection: flush > stall > load; invalid or post-halt loads become bubbles.
  always_comb begin
    valid_nxt_s         = valid_r;
    addr_nxt_s          = addr_r;
    data_nxt_s          = data_r;
    mem_read_nxt_s      = mem_read_r;
    mem_write_nxt_s     = mem_write_r;
    bhw_nxt_s           = bhw_r;
    rd_nxt_s            = rd_r;
    reg_write_nxt_s     = reg_write_r;
    mem_to_reg_nxt_s    = mem_to_reg_r;
    misalign_nxt_s      = misalign_r;
    misalign_addr_nxt_s = misalign_addr_r;
    misalign_seen_nxt_s = misalign_seen_r;
    halted_nxt_s        = halted_r;
    count_nxt_s         = count_r;

    bubble_s = i_flush | (~i_stall & (~i_valid | halted_r));
    fault_s  = (i_mem_read | i_mem_write) & is_misaligned(i_BHW, i_alu_result[1:0]);

    if (bubble_s) begin
      // Bubble: kill controls, keep data fields and BHW frozen.
      valid_nxt_s      = 1'b0;
      mem_read_nxt_s   = 1'b0;
      mem_write_nxt_s  = 1'b0;
      reg_write_nxt_s  = 1'b0;
      mem_to_reg_nxt_s = 1'b0;
      misalign_nxt_s   = 1'b0;
    end else if (!i_stall) begin
      valid_nxt_s      = 1'b1;
      addr_nxt_s       = i_alu_result;
      data_nxt_s       = i_store_data;
      bhw_nxt_s        = i_BHW;
      rd_nxt_s         = i_rd_addr;
      mem_to_reg_nxt_s = i_mem_to_reg;
      misalign_nxt_s   = fault_s;
      // A blocked access stays valid but cannot touch memory or the register file.
      mem_read_nxt_s   = i_mem_read  & ~fault_s;
      mem_write_nxt_s  = i_mem_write & ~fault_s;
      reg_write_nxt_s  = i_reg_write & ~fault_s;
      if (i_halt) begin
        halted_nxt_s = 1'b1;
      end else begin
        halted_nxt_s = halted_r;
      end
      if (fault_s && !misalign_seen_r) begin
        misalign_addr_nxt_s = i_alu_result;
        misalign_seen_nxt_s = 1'b1;
      end else begin
        misalign_addr_nxt_s = misalign_addr_r;
      end
      if (!fault_s && (count_r != CNT_MAX)) begin
        count_nxt_s = count_r + CNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      // Stall: everything holds, including the misalign pulse.
      count_nxt_s = count_r;
    end

    fwd_en_nxt_s = valid_nxt_s & reg_write_nxt_s & ~mem_to_reg_nxt_s &
                   (rd_nxt_s != {NB_REG{1'b0}});
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_r         <= 1'b0;
      addr_r          <= {NB_WIDTH{1'b0}};
      data_r          <= {NB_WIDTH{1'b0}};
      mem_read_r      <= 1'b0;
      mem_write_r     <= 1'b0;
      bhw_r           <= 3'b000;
      rd_r            <= {NB_REG{1'b0}};
      reg_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      fwd_en_r        <= 1'b0;
      misalign_r      <= 1'b0;
      misalign_addr_r <= {NB_WIDTH{1'b0}};
      misalign_seen_r <= 1'b0;
      halted_r        <= 1'b0;
      count_r         <= {NB_CNT{1'b0}};
    end else begin
      valid_r         <= valid_nxt_s;
      addr_r          <= addr_nxt_s;
      data_r          <= data_nxt_s;
      mem_read_r      <= mem_read_nxt_s;
      mem_write_r     <= mem_write_nxt_s;
      bhw_r           <= bhw_nxt_s;
      rd_r            <= rd_nxt_s;
      reg_write_r     <= reg_write_nxt_s;
      mem_to_reg_r    <= mem_to_reg_nxt_s;
      fwd_en_r        <= fwd_en_nxt_s;
      misalign_r      <= misalign_nxt_s;
      misalign_addr_r <= misalign_addr_nxt_s;
      misalign_seen_r <= misalign_seen_nxt_s;
      halted_r        <= halted_nxt_s;
      count_r         <= count_nxt_s;
    end
  end

  assign o_valid         = valid_r;
  assign o_mem_addr      = addr_r;
  assign o_mem_data      = data_r;
  assign o_mem_read      = mem_read_r;
  assign o_mem_write     = mem_write_r;
  assign o_BHW           = bhw_r;
  assign o_rd_addr       = rd_r;
  assign o_reg_write     = reg_write_r;
  assign o_mem_to_reg    = mem_to_reg_r;
  assign o_fwd_en        = fwd_en_r;
  assign o_misalign      = misalign_r;
  assign o_misalign_addr = misalign_addr_r;
  assign o_halted        = halted_r;
  assign o_instr_count   = count_r;

endmodule

// File: tb/tb_ex_mem_latch.sv
module tb_ex_mem_latch;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_flush, i_valid;
  logic [31:0] i_alu_result, i_store_data;
  logic [4:0]  i_rd_addr;
  logic        i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write, i_halt;
  logic [2:0]  i_BHW;

  logic        o_valid, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg;
  logic        o_fwd_en, o_misalign, o_halted;
  logic [31:0] o_mem_addr, o_mem_data, o_misalign_addr, o_instr_count;
  logic [2:0]  o_BHW;
  logic [4:0]  o_rd_addr;

  logic        s_valid, s_mem_read, s_mem_write, s_reg_write, s_mem_to_reg;
  logic        s_fwd_en, s_misalign, s_halted;
  logic [31:0] s_mem_addr, s_mem_data, s_misalign_addr;
  logic [1:0]  s_instr_count;
  logic [2:0]  s_BHW;
  logic [4:0]  s_rd_addr;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  ex_mem_latch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_rd_addr(i_rd_addr), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_BHW(i_BHW), .i_halt(i_halt),
    .o_valid(o_valid), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_BHW(o_BHW),
    .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_fwd_en(o_fwd_en), .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr),
    .o_halted(o_halted), .o_instr_count(o_instr_count)
  );

  // Narrow-counter instance for the saturation check; shares all inputs.
  ex_mem_latch #(.NB_CNT(2)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_valid(i_valid), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .i_rd_addr(i_rd_addr), .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_BHW(i_BHW), .i_halt(i_halt),
    .o_valid(s_valid), .o_mem_addr(s_mem_addr), .o_mem_data(s_mem_data),
    .o_mem_read(s_mem_read), .o_mem_write(s_mem_write), .o_BHW(s_BHW),
    .o_rd_addr(s_rd_addr), .o_reg_write(s_reg_write), .o_mem_to_reg(s_mem_to_reg),
    .o_fwd_en(s_fwd_en), .o_misalign(s_misalign), .o_misalign_addr(s_misalign_addr),
    .o_halted(s_halted), .o_instr_count(s_instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic mr, input logic mw, input logic [2:0] bhw,
                       input logic halt);
    i_valid = v; i_alu_result = alu; i_store_data = sd; i_rd_addr = rd;
    i_reg_write = rw; i_mem_to_reg = m2r; i_mem_read = mr; i_mem_write = mw;
    i_BHW = bhw; i_halt = halt;
  endtask

  // Advance one clock and sample 1 time unit after the active edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    instr(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(); step();
    i_reset = 1'b0;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_addr", o_mem_addr, 32'd0);
    check("rst_count", o_instr_count, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd0);
    check("rst_mis_addr", o_misalign_addr, 32'd0);

    // SW 0x10 <- 0xDEADBEEF
    instr(1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
    step();
    check("sw_write", {31'd0, o_mem_write}, 32'd1);
    check("sw_addr", o_mem_addr, 32'h10);
    check("sw_data", o_mem_data, 32'hDEADBEEF);
    check("sw_bhw", {29'd0, o_BHW}, 32'd3);
    check("sw_count", o_instr_count, 32'd1);

    // LW rd=7 from 0x20, then stall three cycles with changing inputs
    instr(1'b1, 32'h20, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0);
    step();
    check("lw_read", {31'd0, o_mem_read}, 32'd1);
    check("lw_count", o_instr_count, 32'd2);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr(1'b1, 32'h44 + i, 32'h55, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      step();
      check("stall_addr", o_mem_addr, 32'h20);
      check("stall_read", {31'd0, o_mem_read}, 32'd1);
      check("stall_rd", {27'd0, o_rd_addr}, 32'd7);
      check("stall_count", o_instr_count, 32'd2);
    end
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_stall = 1'b0;
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    check("flush_read", {31'd0, o_mem_read}, 32'd0);
    check("flush_addr_kept", o_mem_addr, 32'h20);
    check("flush_count", o_instr_count, 32'd2);

    // SH to 0x21 (misaligned)
    instr(1'b1, 32'h21, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0);
    step();
    check("sh_misalign", {31'd0, o_misalign}, 32'd1);
    check("sh_write", {31'd0, o_mem_write}, 32'd0);
    check("sh_valid", {31'd0, o_valid}, 32'd1);
    check("sh_mis_addr", o_misalign_addr, 32'h21);
    check("sh_count", o_instr_count, 32'd2);
    // LW from 0x42 (misaligned), first fault address stays
    instr(1'b1, 32'h42, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0);
    step();
    check("lw42_misalign", {31'd0, o_misalign}, 32'd1);
    check("lw42_read", {31'd0, o_mem_read}, 32'd0);
    check("lw42_regwrite", {31'd0, o_reg_write}, 32'd0);
    check("lw42_mis_addr", o_misalign_addr, 32'h21);
    check("lw42_count", o_instr_count, 32'd2);
    // SB to 0x23: bytes never fault
    instr(1'b1, 32'h23, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step();
    check("sb_misalign", {31'd0, o_misalign}, 32'd0);
    check("sb_write", {31'd0, o_mem_write}, 32'd1);
    check("sb_count", o_instr_count, 32'd3);

    // Forwarding tap
    instr(1'b1, 32'h99, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
    step();
    check("add_rd5_fwd", {31'd0, o_fwd_en}, 32'd1);
    instr(1'b1, 32'h99, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
    step();
    check("add_rd0_fwd", {31'd0, o_fwd_en}, 32'd0);
    instr(1'b1, 32'h8, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0);
    step();
    check("lw_rd5_fwd", {31'd0, o_fwd_en}, 32'd0);
    check("fwd_count", o_instr_count, 32'd6);

    // HALT, then SW is swallowed
    instr(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1);
    step();
    check("halt_set", {31'd0, o_halted}, 32'd1);
    check("halt_count", o_instr_count, 32'd7);
    instr(1'b1, 32'h30, 32'h77, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
    step();
    check("post_halt_sticky", {31'd0, o_halted}, 32'd1);
    check("post_halt_write", {31'd0, o_mem_write}, 32'd0);
    check("post_halt_valid", {31'd0, o_valid}, 32'd0);
    check("post_halt_addr", o_mem_addr, 32'h0);
    check("post_halt_count", o_instr_count, 32'd7);

    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("rst2_halted", {31'd0, o_halted}, 32'd0);
    check("rst2_count", o_instr_count, 32'd0);
    check("rst2_mis_addr", o_misalign_addr, 32'd0);
    check("rst2_valid", {31'd0, o_valid}, 32'd0);
    check("rst2_data", o_mem_data, 32'd0);

    // Saturation on the 2-bit counter: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      instr(1'b1, 32'h100 + 32'(4 * i), 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
      step();
      check("sat_count", {30'd0, s_instr_count}, (i < 3) ? 32'(i + 1) : 32'd3);
      check("wide_count", o_instr_count, 32'(i + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
